// File: rtl/sensor_input_stage.sv
// -----------------------------------------------------------------------------
// sensor_input_stage
//
// Front end for the processor wrapper. Produces the four input words the
// processor reads from dmem:
//   sensor_input_to_save (addr 1) - moving average of ADC samples, published
//                                   once per sample tick, zero-extended
//   save_signal          (addr 2) - 32'd1 while the save button is accepted
//   load_signal          (addr 3) - 32'd1 while the load button is accepted
//   counter              (addr 5) - free-running count of sample ticks
//
// Ports:
//   clock                in   master clock, rising edge
//   reset                in   asynchronous reset, active low
//   adc_data  [DATA_W]   in   ADC sample, synchronous to clock
//   adc_valid            in   one-cycle strobe qualifying adc_data
//   save_btn_n           in   raw save push-button, active low, asynchronous
//   load_btn_n           in   raw load push-button, active low, asynchronous
//   sensor_input_to_save out  averaged sample (32 bits)
//   save_signal          out  save level (32 bits, 0 or 1)
//   load_signal          out  load level (32 bits, 0 or 1)
//   counter              out  sample-tick count (32 bits, wraps silently)
//   sample_tick          out  one-cycle pulse per sample period
// -----------------------------------------------------------------------------
module sensor_input_stage #(
  parameter int DATA_W          = 12,
  parameter int AVG_LOG2        = 2,
  parameter int SAMPLE_DIV      = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              save_btn_n,
  input  logic              load_btn_n,
  output logic [31:0]       sensor_input_to_save,
  output logic [31:0]       save_signal,
  output logic [31:0]       load_signal,
  output logic [31:0]       counter,
  output logic              sample_tick
);

  localparam int AVG_DEPTH = 1 << AVG_LOG2;
  localparam int SUM_W     = DATA_W + AVG_LOG2;
  localparam int DIV_W     = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CNT_W     = ($clog2(DEBOUNCE_CYCLES) > 18) ? $clog2(DEBOUNCE_CYCLES) : 18;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    RELEASING = 2'd3
  } btn_state_e;

  // ---------------------------------------------------------------------------
  // Sample divider, tick counter and average publication
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_reg;
  logic             tick_reg;
  logic [31:0]      counter_reg;
  logic [31:0]      avg_reg;
  logic [SUM_W-1:0] sum_reg;
  logic             div_last;

  assign div_last = (div_cnt_reg == DIV_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_cnt_reg <= '0;
      tick_reg    <= 1'b0;
      counter_reg <= '0;
      avg_reg     <= '0;
    end else begin
      tick_reg <= div_last;
      if (div_last) begin
        div_cnt_reg <= '0;
        counter_reg <= counter_reg + 32'd1;
        // Uses the sum as registered before this edge, so a sample arriving
        // in this same cycle is counted in the next period.
        avg_reg     <= 32'(sum_reg >> AVG_LOG2);
      end else begin
        div_cnt_reg <= div_cnt_reg + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Moving-average window: shift register of the last AVG_DEPTH samples with
  // a running sum, so each update costs one add and one subtract.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] sample_buf [AVG_DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < AVG_DEPTH; i++) begin
        sample_buf[i] <= '0;
      end
      sum_reg <= '0;
    end else if (adc_valid) begin
      for (int i = AVG_DEPTH - 1; i > 0; i--) begin
        sample_buf[i] <= sample_buf[i-1];
      end
      sample_buf[0] <= adc_data;
      sum_reg       <= sum_reg + SUM_W'(adc_data) - SUM_W'(sample_buf[AVG_DEPTH-1]);
    end
  end

  // ---------------------------------------------------------------------------
  // Buttons: index 0 = save, index 1 = load.
  // ---------------------------------------------------------------------------
  logic [1:0] btn_raw_n;
  logic [1:0] sig_reg;    // accepted levels
  logic [1:0] arm_done;   // debounced press waiting only on the interlock
  logic [1:0] may_press;  // interlock permission to enter PRESSED

  assign btn_raw_n = {load_btn_n, save_btn_n};

  // Save may press whenever load is not asserted. Load additionally yields to
  // a save that enters PRESSED on the same edge, so save wins ties.
  assign may_press[0] = ~sig_reg[1];
  assign may_press[1] = ~sig_reg[0] & ~(arm_done[0] & ~sig_reg[1]);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic             sync1_reg;
      logic             sync2_reg;
      logic             btn;
      btn_state_e       state_reg;
      btn_state_e       state_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             sig_next;

      // Synchronizer idles at the released (high) level.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          sync1_reg <= 1'b1;
          sync2_reg <= 1'b1;
        end else begin
          sync1_reg <= btn_raw_n[gi];
          sync2_reg <= sync1_reg;
        end
      end

      assign btn          = ~sync2_reg;
      assign arm_done[gi] = (state_reg == ARMING) && btn && (cnt_reg == CNT_TERM);

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
          IDLE: begin
            if (btn) begin
              state_next = ARMING;
              cnt_next   = '0;
            end
          end
          ARMING: begin
            if (!btn) begin
              state_next = IDLE;
            end else if (cnt_reg == CNT_TERM) begin
              // Counter stays saturated while the other button holds us off.
              if (may_press[gi]) begin
                state_next = PRESSED;
              end
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          PRESSED: begin
            if (!btn) begin
              state_next = RELEASING;
              cnt_next   = '0;
            end
          end
          RELEASING: begin
            if (btn) begin
              state_next = PRESSED;
            end else if (cnt_reg == CNT_TERM) begin
              state_next = IDLE;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
          default: begin
            state_next = IDLE;
          end
        endcase
        sig_next = (state_next == PRESSED) || (state_next == RELEASING);
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          state_reg   <= IDLE;
          cnt_reg     <= '0;
          sig_reg[gi] <= 1'b0;
        end else begin
          state_reg   <= state_next;
          cnt_reg     <= cnt_next;
          sig_reg[gi] <= sig_next;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sensor_input_to_save = avg_reg;
  assign save_signal          = {31'd0, sig_reg[0]};
  assign load_signal          = {31'd0, sig_reg[1]};
  assign counter              = counter_reg;
  assign sample_tick          = tick_reg;

endmodule

// File: tb/tb_sensor_input_stage.sv
// -----------------------------------------------------------------------------
// tb_sensor_input_stage
//
// Directed bench for sensor_input_stage with SAMPLE_DIV=4, DEBOUNCE_CYCLES=3.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, half a period away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_sensor_input_stage;

  localparam int DATA_W = 12;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_valid = 1'b0;
  logic              save_btn_n = 1'b1;
  logic              load_btn_n = 1'b1;
  logic [31:0]       sensor_input_to_save;
  logic [31:0]       save_signal;
  logic [31:0]       load_signal;
  logic [31:0]       counter;
  logic              sample_tick;

  int checks = 0;
  int errors = 0;

  sensor_input_stage #(
    .DATA_W          (DATA_W),
    .AVG_LOG2        (2),
    .SAMPLE_DIV      (4),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .adc_data             (adc_data),
    .adc_valid            (adc_valid),
    .save_btn_n           (save_btn_n),
    .load_btn_n           (load_btn_n),
    .sensor_input_to_save (sensor_input_to_save),
    .save_signal          (save_signal),
    .load_signal          (load_signal),
    .counter              (counter),
    .sample_tick          (sample_tick)
  );

  always #5 clock = ~clock;

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if (sensor_input_to_save !== 32'd0) begin
      errors++; $display("FAIL reset_avg: got %0d expected 0", sensor_input_to_save);
    end
    checks++;
    if (save_signal !== 32'd0 || load_signal !== 32'd0) begin
      errors++; $display("FAIL reset_btn: got save=%0d load=%0d expected 0 0", save_signal, load_signal);
    end
    checks++;
    if (counter !== 32'd0 || sample_tick !== 1'b0) begin
      errors++; $display("FAIL reset_div: got counter=%0d tick=%0b expected 0 0", counter, sample_tick);
    end
    $display("reset: outputs checked while held");
    reset = 1'b1;
  endtask

  // Called right after reset release on a falling edge.
  task automatic test_divider();
    logic [31:0] exp_cnt;
    logic        exp_tick;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      exp_tick = (c % 4 == 0);
      exp_cnt  = 32'(c / 4);
      checks++;
      if (sample_tick !== exp_tick || counter !== exp_cnt) begin
        errors++;
        $display("FAIL divider_c%0d: got tick=%0b counter=%0d expected tick=%0b counter=%0d",
                 c, sample_tick, counter, exp_tick, exp_cnt);
      end
      $display("divider: cycle %0d tick=%0b counter=%0d", c, sample_tick, counter);
    end
  endtask

  // Called on a tick cycle (divider at 0): preload the counter near wrap.
  task automatic test_counter_wrap();
    force dut.counter_reg = 32'hFFFF_FFFF;
    #1;
    release dut.counter_reg;
    repeat (3) @(negedge clock);
    checks++;
    if (counter !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL wrap_hold: got %h expected ffffffff", counter);
    end
    @(negedge clock);
    checks++;
    if (sample_tick !== 1'b1 || counter !== 32'd0) begin
      errors++; $display("FAIL wrap_zero: got tick=%0b counter=%h expected 1 00000000", sample_tick, counter);
    end
    $display("wrap: counter=%h after tick", counter);
  endtask

  task automatic test_average();
    logic [11:0] ramp [4];
    logic [31:0] exp_avg [4];
    bit          found;
    ramp[0] = 12'd100; ramp[1] = 12'd200; ramp[2] = 12'd300; ramp[3] = 12'd400;
    // Sample in the last cycle of a period is excluded from that period's
    // average: 100+200+300 -> 150, then the full 1000 -> 250. The same holds
    // for the 4095 burst: 3*4095+400 -> 3171, then 4*4095 -> 4095.
    exp_avg[0] = 32'd150; exp_avg[1] = 32'd250; exp_avg[2] = 32'd3171; exp_avg[3] = 32'd4095;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clock);
      if (sample_tick) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL avg_sync: got no tick expected a tick within 8 cycles");
    end
    for (int p = 0; p < 4; p++) begin
      for (int s = 0; s < 4; s++) begin
        if (p == 0 || p == 2) begin
          adc_valid = 1'b1;
          adc_data  = (p == 0) ? ramp[s] : 12'hFFF;
        end
        @(negedge clock);
      end
      adc_valid = 1'b0;
      checks++;
      if (sample_tick !== 1'b1 || sensor_input_to_save !== exp_avg[p]) begin
        errors++;
        $display("FAIL avg_p%0d: got tick=%0b avg=%0d expected tick=1 avg=%0d",
                 p, sample_tick, sensor_input_to_save, exp_avg[p]);
      end
      $display("average: period %0d avg=%0d", p, sensor_input_to_save);
    end
    repeat (4) @(negedge clock);
    checks++;
    if (sensor_input_to_save !== 32'h0000_0FFF) begin
      errors++; $display("FAIL avg_hold: got %h expected 00000fff", sensor_input_to_save);
    end
    $display("average: held avg=%h", sensor_input_to_save);
  endtask

  task automatic test_debounce();
    save_btn_n = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clock);
      checks++;
      if (save_signal !== ((e == 6) ? 32'd1 : 32'd0) || load_signal !== 32'd0) begin
        errors++; $display("FAIL press_e%0d: got save=%0d load=%0d expected save=%0d load=0",
                           e, save_signal, load_signal, (e == 6));
      end
    end
    $display("debounce: press accepted save=%0d", save_signal);
    save_btn_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clock);
      checks++;
      if (save_signal !== ((e == 6) ? 32'd0 : 32'd1)) begin
        errors++; $display("FAIL release_e%0d: got %0d expected %0d", e, save_signal, (e != 6));
      end
    end
    $display("debounce: release accepted save=%0d", save_signal);
  endtask

  task automatic test_glitch();
    save_btn_n = 1'b0;
    repeat (2) @(negedge clock);
    save_btn_n = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clock);
      checks++;
      if (save_signal !== 32'd0) begin
        errors++; $display("FAIL glitch_e%0d: got %0d expected 0", e, save_signal);
      end
    end
    // A fresh press must need the full debounce, showing the FSM went idle.
    save_btn_n = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clock);
      checks++;
      if (save_signal !== ((e == 6) ? 32'd1 : 32'd0)) begin
        errors++; $display("FAIL glitch_repress_e%0d: got %0d expected %0d", e, save_signal, (e == 6));
      end
    end
    save_btn_n = 1'b1;
    repeat (8) @(negedge clock);
    $display("glitch: rejected, re-press accepted");
  endtask

  task automatic test_interlock();
    load_btn_n = 1'b0;
    repeat (6) @(negedge clock);
    checks++;
    if (load_signal !== 32'd1) begin
      errors++; $display("FAIL lock_load_on: got %0d expected 1", load_signal);
    end
    save_btn_n = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clock);
      checks++;
      if (save_signal !== 32'd0 || load_signal !== 32'd1) begin
        errors++; $display("FAIL lock_block_e%0d: got save=%0d load=%0d expected 0 1", e, save_signal, load_signal);
      end
    end
    load_btn_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clock);
      checks++;
      if (save_signal !== 32'd0 || load_signal !== ((e == 6) ? 32'd0 : 32'd1)) begin
        errors++; $display("FAIL lock_handover_e%0d: got save=%0d load=%0d expected 0 %0d",
                           e, save_signal, load_signal, (e != 6));
      end
    end
    @(negedge clock);
    checks++;
    if (save_signal !== 32'd1 || load_signal !== 32'd0) begin
      errors++; $display("FAIL lock_save_on: got save=%0d load=%0d expected 1 0", save_signal, load_signal);
    end
    $display("interlock: save took over after load release");
    save_btn_n = 1'b1;
    repeat (8) @(negedge clock);
    checks++;
    if (save_signal !== 32'd0) begin
      errors++; $display("FAIL lock_save_off: got %0d expected 0", save_signal);
    end
    // Simultaneous press: save wins, load never asserts.
    save_btn_n = 1'b0;
    load_btn_n = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clock);
      checks++;
      if (save_signal !== ((e >= 6) ? 32'd1 : 32'd0) || load_signal !== 32'd0) begin
        errors++; $display("FAIL tie_e%0d: got save=%0d load=%0d expected %0d 0",
                           e, save_signal, load_signal, (e >= 6));
      end
    end
    $display("interlock: tie resolved save=%0d load=%0d", save_signal, load_signal);
    save_btn_n = 1'b1;
    load_btn_n = 1'b1;
    repeat (8) @(negedge clock);
    checks++;
    if (save_signal !== 32'd0 || load_signal !== 32'd0) begin
      errors++; $display("FAIL tie_release: got save=%0d load=%0d expected 0 0", save_signal, load_signal);
    end
  endtask

  task automatic test_reset_mid();
    save_btn_n = 1'b0;
    repeat (6) @(negedge clock);
    checks++;
    if (save_signal !== 32'd1 || sensor_input_to_save === 32'd0) begin
      errors++; $display("FAIL mid_setup: got save=%0d avg=%0d expected 1 and nonzero", save_signal, sensor_input_to_save);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (save_signal !== 32'd0 || load_signal !== 32'd0 || sensor_input_to_save !== 32'd0 ||
        counter !== 32'd0 || sample_tick !== 1'b0) begin
      errors++; $display("FAIL mid_async: got save=%0d load=%0d avg=%0d counter=%0d tick=%0b expected all 0",
                         save_signal, load_signal, sensor_input_to_save, counter, sample_tick);
    end
    $display("reset_mid: outputs cleared asynchronously");
    @(negedge clock);
    reset = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(negedge clock);
      checks++;
      if (save_signal !== ((e == 6) ? 32'd1 : 32'd0)) begin
        errors++; $display("FAIL mid_repress_e%0d: got %0d expected %0d", e, save_signal, (e == 6));
      end
      if (e == 4) begin
        checks++;
        if (sample_tick !== 1'b1 || counter !== 32'd1) begin
          errors++; $display("FAIL mid_div: got tick=%0b counter=%0d expected 1 1", sample_tick, counter);
        end
      end
    end
    $display("reset_mid: held button debounced again save=%0d", save_signal);
    save_btn_n = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  initial begin
    test_reset();
    test_divider();
    test_counter_wrap();
    test_average();
    test_debounce();
    test_glitch();
    test_interlock();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
